// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the Chip-8 RAM arbiter.
// The ROM-protection option is selected with macro CHIP8_ROM_PROTECT_EN in chip8_mem_arbiter.
package chip8_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    // Interpreter/font area that stays read-only for CPU and blitter when protection is built in
    localparam logic [11:0] PROT_LIMIT = 12'h200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        UPL = 2'd0,
        CPU = 2'd1,
        BLT = 2'd2
    } req_id_e;

    function automatic logic is_rom_addr(input logic [31:0] addr);
        return (addr < 32'(PROT_LIMIT));
    endfunction

endpackage

// File: rtl/chip8_rr_arb2.sv
// Two-way round-robin pick; last=1 means requester 0 was granted most recently.
module chip8_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    // Contention goes to whoever was not served last; a lone requester always wins
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port RAM arbiter for upload, CPU and blitter; one access per IDLE->ISSUE->DONE pass.
// Define CHIP8_ROM_PROTECT_EN to drop CPU/blitter writes below PROT_LIMIT and report prot_err.
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_en,
    input  logic [ADDR_W-1:0] up_a,
    input  logic [DATA_W-1:0] up_d,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rd,
    input  logic              blt_req,
    input  logic              blt_we,
    input  logic [ADDR_W-1:0] blt_a,
    input  logic [DATA_W-1:0] blt_wd,
    output logic              blt_ack,
    output logic [DATA_W-1:0] blt_rd,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              up_ovf,
    output logic              prot_err
);

    arb_state_e        state_r;
    arb_state_e        state_nx_s;
    req_id_e           owner_r;
    req_id_e           sel_id_s;
    logic              up_pend_r;
    logic [ADDR_W-1:0] up_a_r;
    logic [DATA_W-1:0] up_d_r;
    logic              last_cpu_r;
    logic              cpu_live_s;
    logic              blt_live_s;
    logic              gnt_cpu_s;
    logic              gnt_blt_s;
    logic              is_idle_s;
    logic              take_upl_s;
    logic              take_cpu_s;
    logic              take_blt_s;
    logic              start_s;
    logic              done_cpu_s;
    logic              done_blt_s;
    logic [ADDR_W-1:0] sel_a_s;
    logic              sel_we_s;
    logic [DATA_W-1:0] sel_wd_s;
    logic              sel_block_s;

    // A requester sees its ack this cycle and drops req on the next edge, so it must not re-win now
    assign cpu_live_s = cpu_req & ~cpu_ack;
    assign blt_live_s = blt_req & ~blt_ack;

    chip8_rr_arb2 u_rr (
        .req0 (cpu_live_s),
        .req1 (blt_live_s),
        .last (last_cpu_r),
        .gnt0 (gnt_cpu_s),
        .gnt1 (gnt_blt_s)
    );

    assign is_idle_s  = (state_r == IDLE);
    assign take_upl_s = is_idle_s & up_pend_r;
    assign take_cpu_s = is_idle_s & ~up_pend_r & gnt_cpu_s;
    assign take_blt_s = is_idle_s & ~up_pend_r & gnt_blt_s;
    assign start_s    = take_upl_s | take_cpu_s | take_blt_s;
    assign done_cpu_s = (state_r == DONE) && (owner_r == CPU);
    assign done_blt_s = (state_r == DONE) && (owner_r == BLT);

    // Winner's access fields; uploads are always writes
    always_comb begin
        sel_id_s = UPL;
        sel_a_s  = up_a_r;
        sel_we_s = 1'b1;
        sel_wd_s = up_d_r;
        if (take_cpu_s) begin
            sel_id_s = CPU;
            sel_a_s  = cpu_a;
            sel_we_s = cpu_we;
            sel_wd_s = cpu_wd;
        end else if (take_blt_s) begin
            sel_id_s = BLT;
            sel_a_s  = blt_a;
            sel_we_s = blt_we;
            sel_wd_s = blt_wd;
        end else begin
            sel_id_s = UPL;
            sel_a_s  = up_a_r;
            sel_we_s = 1'b1;
            sel_wd_s = up_d_r;
        end
    end

`ifdef CHIP8_ROM_PROTECT_EN
    assign sel_block_s = (sel_id_s != UPL) && sel_we_s && is_rom_addr(32'(sel_a_s));
`else
    assign sel_block_s = 1'b0;
`endif

    // Next-state: an access, once started, always runs through ISSUE and DONE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE:   state_nx_s = DONE;
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Owner of the in-flight access and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r    <= UPL;
            last_cpu_r <= 1'b0;
        end else if (start_s) begin
            owner_r <= sel_id_s;
            if (take_cpu_s || take_blt_s) begin
                last_cpu_r <= take_cpu_s;
            end
        end
    end

    // One-entry upload buffer; a strobe arriving while it is still full is lost and flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            up_pend_r <= 1'b0;
            up_a_r    <= {ADDR_W{1'b0}};
            up_d_r    <= {DATA_W{1'b0}};
            up_ovf    <= 1'b0;
        end else if (up_en) begin
            if (up_pend_r && !take_upl_s) begin
                up_ovf <= 1'b1;
            end else begin
                up_pend_r <= 1'b1;
                up_a_r    <= up_a;
                up_d_r    <= up_d;
            end
        end else if (take_upl_s) begin
            up_pend_r <= 1'b0;
        end
    end

    // RAM port: loaded on the way into ISSUE, write enable only ever high during ISSUE
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_a  <= {ADDR_W{1'b0}};
            mem_we <= 1'b0;
            mem_wd <= {DATA_W{1'b0}};
        end else if (start_s) begin
            mem_a  <= sel_a_s;
            mem_we <= sel_we_s & ~sel_block_s;
            mem_wd <= sel_wd_s;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Completion: RAM data is valid during DONE, captured alongside the one-cycle ack
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack <= 1'b0;
            blt_ack <= 1'b0;
            cpu_rd  <= {DATA_W{1'b0}};
            blt_rd  <= {DATA_W{1'b0}};
        end else begin
            cpu_ack <= done_cpu_s;
            blt_ack <= done_blt_s;
            if (done_cpu_s) begin
                cpu_rd <= mem_rd;
            end
            if (done_blt_s) begin
                blt_rd <= mem_rd;
            end
        end
    end

`ifdef CHIP8_ROM_PROTECT_EN
    logic blocked_r;

    // Remember a dropped write so its violation pulse lines up with the ack
    always_ff @(posedge clk) begin
        if (reset) begin
            blocked_r <= 1'b0;
            prot_err  <= 1'b0;
        end else begin
            if (start_s) begin
                blocked_r <= sel_block_s;
            end
            prot_err <= (done_cpu_s || done_blt_s) && blocked_r;
        end
    end
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: vector table, directed corner sequences and
// randomized CPU/blitter/upload traffic checked against a shadow-memory model.
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        up_en;
    logic [11:0] up_a;
    logic [7:0]  up_d;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [11:0] cpu_a;
    logic [7:0]  cpu_wd, cpu_rd;
    logic        blt_req, blt_we, blt_ack;
    logic [11:0] blt_a;
    logic [7:0]  blt_wd, blt_rd;
    logic [11:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;
    logic        up_ovf, prot_err;

    int          checks = 0;
    int          failures = 0;
    int          overlap_cnt = 0;
    logic        ram_init;
    logic [7:0]  ram    [4096];
    logic [7:0]  shadow [4096];
    logic [23:0] ev_log [$];

    typedef struct {
        logic        is_blt;
        logic        we;
        logic [11:0] a;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
    } vec_t;

    always #5 clk = ~clk;

    chip8_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .up_en(up_en), .up_a(up_a), .up_d(up_d),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
        .cpu_ack(cpu_ack), .cpu_rd(cpu_rd),
        .blt_req(blt_req), .blt_we(blt_we), .blt_a(blt_a), .blt_wd(blt_wd),
        .blt_ack(blt_ack), .blt_rd(blt_rd),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .up_ovf(up_ovf), .prot_err(prot_err)
    );

    function automatic logic [7:0] init_val(input logic [11:0] a);
        if (a == 12'h300) return 8'hA5;
        return a[7:0] ^ 8'h5C ^ {a[11:8], 4'h0};
    endfunction

    // Single-port RAM with registered (read-before-write) data
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val(12'(i));
        end else if (mem_we) begin
            ram[mem_a] <= mem_wd;
        end
        mem_rd <= ram[mem_a];
    end

    always @(negedge clk) begin
        if (cpu_ack && blt_ack) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step_log(input bit drop);
        tick();
        if (mem_we)  ev_log.push_back({4'h3, mem_a, mem_wd});
        if (cpu_ack) ev_log.push_back({4'h1, 12'h000, 8'h00});
        if (blt_ack) ev_log.push_back({4'h2, 12'h000, 8'h00});
        if (drop && cpu_ack) cpu_req = 1'b0;
        if (drop && blt_ack) blt_req = 1'b0;
    endtask

    task automatic do_access(input bit is_blt, input bit we, input logic [11:0] a,
                             input logic [7:0] d, output int lat, output logic [7:0] rd,
                             output logic prot);
        bit got;
        if (is_blt) begin
            blt_req = 1'b1; blt_we = we; blt_a = a; blt_wd = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_wd = d;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            tick();
            lat++;
            got = is_blt ? blt_ack : cpu_ack;
        end
        rd   = is_blt ? blt_rd : cpu_rd;
        prot = prot_err;
        if (is_blt) blt_req = 1'b0;
        else        cpu_req = 1'b0;
        check($sformatf("ack_arrived_%s", is_blt ? "blt" : "cpu"), 64'(got), 64'd1);
        tick();
    endtask

    task automatic rand_master(input bit is_blt);
        int          lat;
        logic [7:0]  rd;
        logic        prot;
        logic        we;
        logic [11:0] a;
        logic [7:0]  d;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            we = 1'($urandom_range(0, 1));
            a  = (is_blt ? 12'h800 : 12'h400) + 12'($urandom_range(0, 1023));
            d  = 8'($urandom);
            do_access(is_blt, we, a, d, lat, rd, prot);
            check("rand_prot", 64'(prot), 64'd0);
            if (we) shadow[a] = d;
            else    check($sformatf("rand_rd_%s_%03h", is_blt ? "blt" : "cpu", a), 64'(rd), 64'(shadow[a]));
        end
    endtask

    task automatic rand_uploader();
        for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(5, 9)) tick();
            up_en = 1'b1;
            up_a  = 12'hC00 + 12'($urandom_range(0, 255));
            up_d  = 8'($urandom);
            shadow[up_a] = up_d;
            tick();
            up_en = 1'b0;
        end
    endtask

    initial begin
        vec_t       vecs [10];
        int         lat;
        int         mism;
        logic [7:0] rd;
        logic       prot;

        reset = 1'b1; ram_init = 1'b1;
        up_en = 1'b0; up_a = 12'h000; up_d = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 12'h000; cpu_wd = 8'h00;
        blt_req = 1'b0; blt_we = 1'b0; blt_a = 12'h000; blt_wd = 8'h00;
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(12'(i));

        vecs[0] = '{1'b0, 1'b0, 12'h300, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 12'h301, 8'h00, init_val(12'h301)};
        vecs[2] = '{1'b0, 1'b1, 12'h500, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 12'h500, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 1'b1, 12'h7FF, 8'hC3, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 12'h7FF, 8'h00, 8'hC3};
        vecs[6] = '{1'b0, 1'b0, 12'h000, 8'h00, init_val(12'h000)};
        vecs[7] = '{1'b1, 1'b0, 12'hFFF, 8'h00, init_val(12'hFFF)};
        vecs[8] = '{1'b0, 1'b1, 12'hFFF, 8'h00, 8'h00};
        vecs[9] = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'h00};

        tick(); tick();
        ram_init = 1'b0;
        check("reset_outputs",
              {23'd0, cpu_ack, blt_ack, mem_we, up_ovf, prot_err, mem_a, mem_wd, cpu_rd, blt_rd},
              64'd0);
        reset = 1'b0;
        tick();

        // Vector table: single accesses from an idle arbiter
        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].is_blt, vecs[i].we, vecs[i].a, vecs[i].wd, lat, rd, prot);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("vec%0d_prot", i), 64'(prot), 64'd0);
            if (vecs[i].we) begin
                shadow[vecs[i].a] = vecs[i].wd;
                check($sformatf("vec%0d_ram", i), 64'(ram[vecs[i].a]), 64'(vecs[i].wd));
            end else begin
                check($sformatf("vec%0d_rd", i), 64'(rd), 64'(vecs[i].exp_rd));
            end
        end

        // Both requesters held from reset: grants alternate starting with the CPU
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h300;
        blt_req = 1'b1; blt_we = 1'b0; blt_a = 12'h301;
        tick(); tick();
        reset = 1'b0;
        ev_log.delete();
        repeat (13) step_log(1'b0);
        cpu_req = 1'b0; blt_req = 1'b0;
        repeat (6) tick();
        check("alt_ack_count_ge4", 64'(ev_log.size() >= 4), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("alt_grant%0d", k), 64'(ev_log[k][23:20]), (k % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Upload strobe during a CPU ISSUE waits for the CPU access to finish
        ev_log.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h300;
        step_log(1'b1);
        up_en = 1'b1; up_a = 12'h200; up_d = 8'h12;
        shadow[12'h200] = 8'h12;
        step_log(1'b1);
        up_en = 1'b0;
        repeat (6) step_log(1'b1);
        check("upl_events", 64'(ev_log.size()), 64'd2);
        check("upl_first_cpu_ack", 64'(ev_log[0]), {40'd0, 4'h1, 12'h000, 8'h00});
        check("upl_then_write", 64'(ev_log[1]), {40'd0, 4'h3, 12'h200, 8'h12});
        check("upl_cpu_rd", 64'(cpu_rd), 64'hA5);

        // Two strobes while busy: overflow flagged, only the first reaches RAM
        ev_log.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h330;
        step_log(1'b1);
        up_en = 1'b1; up_a = 12'h210; up_d = 8'h34;
        shadow[12'h210] = 8'h34;
        step_log(1'b1);
        up_a = 12'h211; up_d = 8'h56;
        step_log(1'b1);
        up_en = 1'b0;
        repeat (6) step_log(1'b1);
        check("ovf_flag", 64'(up_ovf), 64'd1);
        check("ovf_events", 64'(ev_log.size()), 64'd2);
        check("ovf_first_write", 64'(ev_log[1]), {40'd0, 4'h3, 12'h210, 8'h34});
        check("ovf_dropped_ram", 64'(ram[12'h211]), 64'(shadow[12'h211]));

        // Reset while the blitter access is in DONE
        blt_req = 1'b1; blt_we = 1'b0; blt_a = 12'h320;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_in_done_outputs",
              {23'd0, cpu_ack, blt_ack, mem_we, up_ovf, prot_err, mem_a, mem_wd, cpu_rd, blt_rd},
              64'd0);
        reset = 1'b0;
        lat = 0;
        while (!blt_ack && lat < 10) begin
            tick();
            lat++;
        end
        check("rst_reserve_latency", 64'(lat), 64'd3);
        check("rst_reserve_rd", 64'(blt_rd), 64'(shadow[12'h320]));
        blt_req = 1'b0;
        tick();

        // CPU write just below the program area
        do_access(1'b0, 1'b1, 12'h1FF, 8'h77, lat, rd, prot);
`ifdef CHIP8_ROM_PROTECT_EN
        check("rom_prot_err", 64'(prot), 64'd1);
        check("rom_ram_kept", 64'(ram[12'h1FF]), 64'(shadow[12'h1FF]));
`else
        shadow[12'h1FF] = 8'h77;
        check("rom_prot_err", 64'(prot), 64'd0);
        check("rom_ram_written", 64'(ram[12'h1FF]), 64'h77);
`endif
        check("rom_latency", 64'(lat), 64'd3);

        // Randomized concurrent traffic against the shadow memory
        fork
            rand_master(1'b0);
            rand_master(1'b1);
            rand_uploader();
        join
        repeat (10) tick();
        mism = 0;
        for (int i = 0; i < 4096; i++) begin
            if (ram[i] !== shadow[i]) mism++;
        end
        check("final_ram_mismatches", 64'(mism), 64'd0);
        check("rand_no_overflow", 64'(up_ovf), 64'd0);
        check("ack_overlap_cycles", 64'(overlap_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
